// File: rtl/alarm_display_scan_if.sv
// alarm_display_scan_if
// Signal bundle between the clock core / bench (master) and the 4-digit
// multiplexed display scanner (slave). Clock and reset stay plain ports.
interface alarm_display_scan_if;
   logic       ena;        // scan enable
   logic [4:0] hours;      // binary hours, 0-23 legal
   logic [5:0] minutes;    // binary minutes, 0-59 legal
   logic       alarm;      // alarm-active flag
   logic [6:0] seg;        // active-high segments {g,f,e,d,c,b,a}
   logic       dp;         // colon / decimal point
   logic [3:0] an;         // one-hot digit enables, an[3] = hours tens
   logic       alarm_led;  // registered copy of alarm

   modport master (
      output ena, hours, minutes, alarm,
      input  seg, dp, an, alarm_led
   );

   modport slave (
      input  ena, hours, minutes, alarm,
      output seg, dp, an, alarm_led
   );
endinterface

// File: rtl/alarm_display_scan.sv
// alarm_display_scan
// Multiplexed 4-digit HH:MM scanner. A prescaler walks a 2-bit digit index;
// at every frame start the time is snapshotted and converted to BCD by a
// 6-step double-dabble FSM (IDLE -> CONV -> LOAD), then latched into the
// display registers. Out-of-range times show dashes. The colon (dp on
// digit 2) blinks with a phase that toggles every BLINK_FRAMES frames.
// Optional feature macro: ALARM_BLINK_EN -- when defined, a frame whose
// alarm snapshot is 1 and blink phase is 0 is fully blanked.
module alarm_display_scan #(
   parameter int SCAN_DIV     = 1000,  // clk cycles per digit slot, >= 8
   parameter int BLINK_FRAMES = 64     // frames per blink half-period, >= 1
) (
   input  logic                 clk,
   input  logic                 rst,
   alarm_display_scan_if.slave  bus
);

   localparam int              PW        = $clog2(SCAN_DIV);
   localparam int              FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [FW-1:0]   FRAME_MAX = FW'(BLINK_FRAMES - 1);
   localparam logic [3:0]      CODE_DASH = 4'hA;
   localparam logic [2:0]      LAST_ITER = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_LOAD = 2'd2
   } state_t;

   // One double-dabble iteration on {tens, ones, binary[5:0]}: correct any
   // BCD nibble >= 5 by adding 3, then shift the whole vector left by one.
   function automatic logic [13:0] dd_step(input logic [13:0] v);
      logic [13:0] t;
      t = v;
      if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
      if (t[9:6]   >= 4'd5) t[9:6]   = t[9:6]   + 4'd3;
      return {t[12:0], 1'b0};
   endfunction

   // Digit code to active-high segments {g,f,e,d,c,b,a}; codes above 9 show a dash.
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // Scan timing
   logic [PW-1:0]    r_presc;
   logic [1:0]       r_idx;
   logic             w_tick;
   logic             w_frame_start;

   // Converter FSM and datapath
   state_t           r_state;
   state_t           w_next_state;
   logic [2:0]       r_iter;
   logic [13:0]      r_dd_h;
   logic [13:0]      r_dd_m;
   logic             r_bad;
   logic             w_conv_start;
   logic             w_conv_step;
   logic             w_load;

   // Display state
   logic [3:0][3:0]  r_dig;      // [3]=hours tens ... [0]=minutes ones
   logic             r_valid;
   logic [FW-1:0]    r_frame_cnt;
   logic             r_phase;
   logic             w_blank;

   // Output stage
   logic [6:0]       r_seg;
   logic [3:0]       r_an;
   logic             r_dp;
   logic             r_alarm_led;
   logic [6:0]       w_seg_nxt;
   logic [3:0]       w_an_nxt;
   logic             w_dp_nxt;

`ifdef ALARM_BLINK_EN
   logic             r_snap_alarm;
`endif

   assign w_tick        = bus.ena && (r_presc == PRESC_MAX);
   assign w_frame_start = w_tick && (r_idx == 2'd3);

   // Prescaler and digit index: advance only while enabled, hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (rst) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else if (bus.ena) begin
         if (w_tick) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   // Converter state register; frozen while scanning is disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else if (bus.ena) begin
         r_state <= w_next_state;
      end
   end

   // Converter next-state logic; a frame start outside IDLE is ignored.
   always_comb begin
      // NOTE: default assignment first so no branch leaves the signal unassigned and infers a latch.
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_frame_start)       w_next_state = S_CONV;
         S_CONV:  if (r_iter == LAST_ITER) w_next_state = S_LOAD;
         S_LOAD:                           w_next_state = S_IDLE;
         default:                          w_next_state = S_IDLE;
      endcase
   end

   // Converter control strobes decoded from the current state.
   always_comb begin
      w_conv_start = 1'b0;
      w_conv_step  = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         S_IDLE:  w_conv_start = w_frame_start;
         S_CONV:  w_conv_step  = bus.ena;
         S_LOAD:  w_load       = bus.ena;
         default: ;
      endcase
   end

   // Snapshot inputs at frame start, then run the six double-dabble steps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_iter       <= '0;
         r_dd_h       <= '0;
         r_dd_m       <= '0;
         r_bad        <= 1'b0;
`ifdef ALARM_BLINK_EN
         r_snap_alarm <= 1'b0;
`endif
      end else if (w_conv_start) begin
         r_iter       <= '0;
         r_dd_h       <= {9'd0, bus.hours};
         r_dd_m       <= {8'd0, bus.minutes};
         r_bad        <= (bus.hours > 5'd23) || (bus.minutes > 6'd59);
`ifdef ALARM_BLINK_EN
         r_snap_alarm <= bus.alarm;
`endif
      end else if (w_conv_step) begin
         r_iter       <= r_iter + 3'd1;
         r_dd_h       <= dd_step(r_dd_h);
         r_dd_m       <= dd_step(r_dd_m);
      end
   end

   // Display registers: written only in LOAD, so an abandoned conversion never lands.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the four digit registers are plain flops, so they are reset; stale digits must never show after reset.
      if (rst) begin
         r_dig   <= '0;
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         if (r_bad) begin
            r_dig <= {CODE_DASH, CODE_DASH, CODE_DASH, CODE_DASH};
         end else begin
            r_dig <= {r_dd_h[13:10], r_dd_h[9:6], r_dd_m[13:10], r_dd_m[9:6]};
         end
      end
   end

   // Frame counter: flip the blink phase once every BLINK_FRAMES frame starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (w_frame_start) begin
         if (r_frame_cnt == FRAME_MAX) begin
            r_frame_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

`ifdef ALARM_BLINK_EN
   assign w_blank = r_snap_alarm && !r_phase;
`else
   assign w_blank = 1'b0;
`endif

   // Next output values: dark while disabled, before the first load, or alarm-blanked.
   always_comb begin
      w_an_nxt  = '0;
      w_seg_nxt = '0;
      w_dp_nxt  = 1'b0;
      if (bus.ena && r_valid && !w_blank) begin
         w_an_nxt  = 4'b0001 << r_idx;
         w_seg_nxt = seg_code(r_dig[r_idx]);
         w_dp_nxt  = (r_idx == 2'd2) && r_phase;
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an  <= '0;
         r_seg <= '0;
         r_dp  <= 1'b0;
      end else begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

   // Alarm LED follows alarm every cycle, independent of the scan enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alarm_led <= 1'b0;
      end else begin
         r_alarm_led <= bus.alarm;
      end
   end

   assign bus.an        = r_an;
   assign bus.seg       = r_seg;
   assign bus.dp        = r_dp;
   assign bus.alarm_led = r_alarm_led;

endmodule

// File: tb/tb_alarm_display_scan.sv
// tb_alarm_display_scan
// Directed bench for alarm_display_scan with SCAN_DIV=8, BLINK_FRAMES=4.
// Cycle n counts rising edges since reset release (or since ena returned);
// outputs are sampled on the falling edge after edge n. With these
// parameters a frame is 32 cycles, frame starts land on edges 32k, and the
// first LOAD becomes visible on the outputs after edge 40.
// Honours ALARM_BLINK_EN for the expected alarm-blink behaviour.
module tb_alarm_display_scan;

   localparam int SCAN_DIV     = 8;
   localparam int BLINK_FRAMES = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   alarm_display_scan_if bus ();

   alarm_display_scan #(
      .SCAN_DIV     (SCAN_DIV),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input logic dp_e);
      check({tag, ".an"},  8'(bus.an),  8'(an_e));
      check({tag, ".seg"}, 8'(bus.seg), 8'(seg_e));
      check({tag, ".dp"},  8'(bus.dp),  8'(dp_e));
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   int cnt;
   int viol;
   int exp_cnt;

   initial begin
      rst         = 1'b1;
      bus.ena     = 1'b1;
      bus.hours   = 5'd12;
      bus.minutes = 6'd34;
      bus.alarm   = 1'b0;
      cycles(2);
      check_out("reset", 4'h0, 7'h00, 1'b0);
      check("reset.alarm_led", 8'(bus.alarm_led), 8'h00);

      // ---- 12:34: blanking before first LOAD, digit map, mid-frame change
      do_reset();
      cycles(1);
      check_out("c1_blank", 4'h0, 7'h00, 1'b0);
      cycles(38);                                   // cycle 39
      check_out("c39_blank", 4'h0, 7'h00, 1'b0);
      cycles(1);                                    // cycle 40: first LOAD visible
      check_out("c40_d0", 4'b0001, 7'h66, 1'b0);
      cycles(1);                                    // cycle 41
      check_out("c41_d1", 4'b0010, 7'h4F, 1'b0);
      cycles(8);                                    // cycle 49
      check_out("c49_d2", 4'b0100, 7'h5B, 1'b0);
      cycles(1);                                    // cycle 50: mid-frame change
      bus.minutes = 6'd35;
      cycles(7);                                    // cycle 57
      check_out("c57_d3", 4'b1000, 7'h06, 1'b0);
      cycles(8);                                    // cycle 65: next frame, old value
      check_out("c65_old", 4'b0001, 7'h66, 1'b0);
      cycles(6);                                    // cycle 71
      check_out("c71_old", 4'b0001, 7'h66, 1'b0);
      cycles(1);                                    // cycle 72: frame start 64 + 8
      check_out("c72_new", 4'b0001, 7'h6D, 1'b0);

      // ---- 24:10 -> dashes, then 23:59 boundary, then minutes 60 -> dashes
      bus.hours   = 5'd24;
      bus.minutes = 6'd10;
      do_reset();
      cycles(40);
      check_out("dash_d0", 4'b0001, 7'h40, 1'b0);
      cycles(1);
      check_out("dash_d1", 4'b0010, 7'h40, 1'b0);
      cycles(8);
      check_out("dash_d2", 4'b0100, 7'h40, 1'b0);
      cycles(8);                                    // cycle 57
      check_out("dash_d3", 4'b1000, 7'h40, 1'b0);
      bus.hours   = 5'd23;
      bus.minutes = 6'd59;
      cycles(15);                                   // cycle 72
      check_out("max_d0", 4'b0001, 7'h6F, 1'b0);
      cycles(1);
      check_out("max_d1", 4'b0010, 7'h6D, 1'b0);
      cycles(8);
      check_out("max_d2", 4'b0100, 7'h4F, 1'b0);
      cycles(8);                                    // cycle 89
      check_out("max_d3", 4'b1000, 7'h5B, 1'b0);
      cycles(1);                                    // cycle 90
      bus.minutes = 6'd60;
      cycles(14);                                   // cycle 104
      check_out("m60_d0", 4'b0001, 7'h40, 1'b0);
      cycles(1);
      check_out("m60_d1", 4'b0010, 7'h40, 1'b0);

      // ---- colon blink over 16 frames: 8 dp cycles in phase-1 frames, only on an=0100
      bus.hours   = 5'd12;
      bus.minutes = 6'd34;
      do_reset();
      cycles(32);
      viol = 0;
      for (int f = 1; f <= 16; f++) begin
         cnt = 0;
         for (int c = 0; c < 32; c++) begin
            cycles(1);
            if (bus.dp === 1'b1) begin
               cnt++;
               if (bus.an !== 4'b0100) viol++;
            end
         end
         exp_cnt = (((f / 4) % 2) == 1) ? 8 : 0;
         check($sformatf("dp_frame%0d", f), 8'(cnt), 8'(exp_cnt));
      end
      check("dp_only_digit2", 8'(viol), 8'd0);

      // ---- alarm = 1: blanking depends on ALARM_BLINK_EN
      bus.alarm = 1'b1;
      do_reset();
      cycles(64);
      check("alarm_led_on", 8'(bus.alarm_led), 8'h01);
      for (int f = 2; f <= 11; f++) begin
         cnt = 0;
         for (int c = 0; c < 32; c++) begin
            cycles(1);
            if (bus.an !== 4'h0) cnt++;
         end
`ifdef ALARM_BLINK_EN
         exp_cnt = (((f / 4) % 2) == 1) ? 32 : 0;
`else
         exp_cnt = 32;
`endif
         check($sformatf("alarm_frame%0d", f), 8'(cnt), 8'(exp_cnt));
      end

      // ---- reset during CONV, ena low, held prescaler, resume
      bus.alarm = 1'b0;
      do_reset();
      cycles(66);                                   // frame 2 conversion in progress
      check_out("c66_d0", 4'b0001, 7'h66, 1'b0);
      rst     = 1'b1;
      bus.ena = 1'b0;
      #1;
      check_out("rst_async", 4'h0, 7'h00, 1'b0);
      check("rst_async.alarm_led", 8'(bus.alarm_led), 8'h00);
      @(negedge clk);
      rst = 1'b0;
      cycles(50);
      check_out("ena0_hold", 4'h0, 7'h00, 1'b0);
      bus.alarm = 1'b1;
      #1;
      check("led_before_edge", 8'(bus.alarm_led), 8'h00);
      cycles(1);
      check("led_after_edge", 8'(bus.alarm_led), 8'h01);
      bus.alarm = 1'b0;
      cycles(1);
      check("led_clear", 8'(bus.alarm_led), 8'h00);
      bus.ena = 1'b1;
      cycles(39);
      check_out("resume_c39", 4'h0, 7'h00, 1'b0);
      cycles(1);
      check_out("resume_c40", 4'b0001, 7'h66, 1'b0);
      cycles(5);                                    // enabled cycle 45
      check_out("resume_c45", 4'b0010, 7'h4F, 1'b0);
      bus.ena = 1'b0;
      cycles(1);
      check_out("pause_1", 4'h0, 7'h00, 1'b0);
      cycles(19);
      check_out("pause_20", 4'h0, 7'h00, 1'b0);
      bus.ena = 1'b1;
      cycles(3);                                    // enabled cycle 48
      check_out("held_c48", 4'b0010, 7'h4F, 1'b0);
      cycles(1);                                    // enabled cycle 49
      check_out("held_c49", 4'b0100, 7'h5B, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
